// File: rtl/instr_fetch_unit_if.sv
// Instruction ROM bus between the fetch unit (master) and the ROM (slave).
interface instr_fetch_unit_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;

    modport master (output rom_addr, input rom_inst);
    modport slave  (input rom_addr, output rom_inst);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction ROM and fills the IF/ID register.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_fetch_unit_if.master       rom,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     br_taken_i,
    input  logic [31:0]              br_target_i,
    input  logic                     halt_req_i,
    output logic [31:0]              if_inst_o,
    output logic [31:0]              if_pc_o,
    output logic                     if_valid_o,
    output logic                     halted_o,
    output logic [CNT_W-1:0]         fetch_count_o
);

    typedef enum logic [1:0] {
        START,
        RUN,
        HALT
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        ifpc_q, ifpc_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // START is a one-cycle bubble after reset; HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            START:   state_d = RUN;
            RUN:     state_d = halt_req_i ? HALT : RUN;
            HALT:    state_d = HALT;
            default: state_d = START;
        endcase
    end

    // Priority in RUN: halt, branch, stall, flush, then a normal fetch.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            if (halt_req_i) begin
                inst_d  = '0;
                ifpc_d  = '0;
                valid_d = 1'b0;
            end else if (br_taken_i) begin
                pc_d    = {br_target_i[31:2], 2'b00};
                inst_d  = '0;
                ifpc_d  = '0;
                valid_d = 1'b0;
            end else if (stall_i) begin
                pc_d    = pc_q;
            end else if (flush_i) begin
                pc_d    = pc_plus4;
                inst_d  = '0;
                ifpc_d  = '0;
                valid_d = 1'b0;
            end else begin
                pc_d    = pc_plus4;
                inst_d  = rom.rom_inst;
                ifpc_d  = pc_q;
                valid_d = 1'b1;
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

    assign rom.rom_addr  = pc_q;
    assign if_inst_o     = inst_q;
    assign if_pc_o       = ifpc_q;
    assign if_valid_o    = valid_q;
    assign halted_o      = (state_q == HALT);
    assign fetch_count_o = cnt_q;

endmodule
